fb_conditioner: RTL and testbench

Upstream front end for the software PLL's feedback input. Synchronizes the raw fb_u pin to clk_50 and deglitches it. Measures the cycle count between qualified rising edges and keeps a 4-deep running average. Flags too-fast and too-slow feedback, which drives the PLL's frequency lockout, and asserts sig_ok after a run of in-range periods.

---
 rtl/fb_conditioner.sv | 166 ++++++++++++++++
 tb/tb_fb_conditioner.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_conditioner.sv
// rtl/fb_conditioner.sv - feedback pin synchronizer, deglitch filter and period qualifier
// Feeds the software PLL: measured period, 4-deep average, too-fast/too-slow flags, sig_ok.
module fb_conditioner #(
   parameter int FILTER_LEN  = 3,
   parameter int PERIOD_MIN  = 238,
   parameter int PERIOD_MAX  = 1000,
   parameter int LOCK_COUNT  = 8,
   parameter int PERIOD_BITS = 16
) (
   input  logic                   clk_50,
   input  logic                   rst_n,
   input  logic                   fb_u,
   output logic                   fb,
   output logic                   fb_rise,
   output logic [PERIOD_BITS-1:0] period,
   output logic                   period_valid,
   output logic [PERIOD_BITS-1:0] period_avg,
   output logic                   too_fast,
   output logic                   too_slow,
   output logic                   sig_ok
);

   localparam int SUM_BITS = PERIOD_BITS + 2;
   localparam logic [PERIOD_BITS-1:0] P_MIN = PERIOD_BITS'(PERIOD_MIN);
   localparam logic [PERIOD_BITS-1:0] P_MAX = PERIOD_BITS'(PERIOD_MAX);
   localparam logic [PERIOD_BITS-1:0] P_SAT = PERIOD_BITS'(PERIOD_MAX + 1);
   localparam logic [3:0]             FLT_TOP = 4'(FILTER_LEN - 1);
   localparam logic [7:0]             LOCK_N  = 8'(LOCK_COUNT);

   logic                            sync1_q, sync2_q;
   logic [3:0]                      flt_cnt_q, flt_cnt_d;
   logic                            fb_q, fb_d;
   logic                            fb_rise_q, fb_rise_d;
   logic [PERIOD_BITS-1:0]          pcnt_q, pcnt_d;
   logic                            have_edge_q, have_edge_d;
   logic [3:0][PERIOD_BITS-1:0]     hist_q, hist_d;
   logic [SUM_BITS-1:0]             sum_q, sum_d, sum_next;
   logic [PERIOD_BITS-1:0]          period_q, period_d;
   logic                            period_valid_q, period_valid_d;
   logic [PERIOD_BITS-1:0]          period_avg_q, period_avg_d;
   logic                            too_fast_q, too_fast_d;
   logic                            too_slow_q, too_slow_d;
   logic [7:0]                      good_cnt_q, good_cnt_d;
   logic                            sig_ok_q, sig_ok_d;

   logic timeout, first_edge, short_p, accept;

   // Level changes only after FILTER_LEN consecutive disagreeing synced samples.
   always_comb begin
      flt_cnt_d = 4'd0;
      fb_d      = fb_q;
      fb_rise_d = 1'b0;
      if (sync2_q != fb_q) begin
         if (flt_cnt_q == FLT_TOP) begin
            fb_d      = ~fb_q;
            fb_rise_d = ~fb_q;
         end else begin
            flt_cnt_d = flt_cnt_q + 4'd1;
         end
      end
   end

   always_comb begin
      pcnt_d = pcnt_q;
      if (fb_rise_q) begin
         pcnt_d = PERIOD_BITS'(1);
      end else if (pcnt_q != P_SAT) begin
         pcnt_d = pcnt_q + PERIOD_BITS'(1);
      end
   end

   // A rise after saturation is indistinguishable from the very first rise.
   assign timeout    = (pcnt_q == P_MAX) && !fb_rise_q;
   assign first_edge = fb_rise_q && (!have_edge_q || (pcnt_q == P_SAT));
   assign short_p    = fb_rise_q && !first_edge && (pcnt_q < P_MIN);
   assign accept     = fb_rise_q && !first_edge && !short_p;
   assign sum_next   = sum_q - SUM_BITS'(hist_q[3]) + SUM_BITS'(pcnt_q);

   always_comb begin
      have_edge_d    = have_edge_q;
      hist_d         = hist_q;
      sum_d          = sum_q;
      period_d       = period_q;
      period_avg_d   = period_avg_q;
      good_cnt_d     = good_cnt_q;
      sig_ok_d       = sig_ok_q;
      period_valid_d = 1'b0;
      too_fast_d     = 1'b0;
      too_slow_d     = 1'b0;

      if (first_edge) begin
         have_edge_d = 1'b1;
      end else if (short_p) begin
         too_fast_d = 1'b1;
         good_cnt_d = 8'd0;
         sig_ok_d   = 1'b0;
      end else if (accept) begin
         period_d       = pcnt_q;
         period_valid_d = 1'b1;
         hist_d         = {hist_q[2:0], pcnt_q};
         sum_d          = sum_next;
         period_avg_d   = PERIOD_BITS'(sum_next >> 2);
         if (good_cnt_q != LOCK_N) begin
            good_cnt_d = good_cnt_q + 8'd1;
         end
         sig_ok_d = (good_cnt_d == LOCK_N);
      end

      if (timeout) begin
         too_slow_d  = 1'b1;
         have_edge_d = 1'b0;
         good_cnt_d  = 8'd0;
         sig_ok_d    = 1'b0;
         hist_d      = '0;
         sum_d       = '0;
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q        <= 1'b0;
         sync2_q        <= 1'b0;
         flt_cnt_q      <= 4'd0;
         fb_q           <= 1'b0;
         fb_rise_q      <= 1'b0;
         pcnt_q         <= '0;
         have_edge_q    <= 1'b0;
         hist_q         <= '0;
         sum_q          <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         period_avg_q   <= '0;
         too_fast_q     <= 1'b0;
         too_slow_q     <= 1'b0;
         good_cnt_q     <= 8'd0;
         sig_ok_q       <= 1'b0;
      end else begin
         sync1_q        <= fb_u;
         sync2_q        <= sync1_q;
         flt_cnt_q      <= flt_cnt_d;
         fb_q           <= fb_d;
         fb_rise_q      <= fb_rise_d;
         pcnt_q         <= pcnt_d;
         have_edge_q    <= have_edge_d;
         hist_q         <= hist_d;
         sum_q          <= sum_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         period_avg_q   <= period_avg_d;
         too_fast_q     <= too_fast_d;
         too_slow_q     <= too_slow_d;
         good_cnt_q     <= good_cnt_d;
         sig_ok_q       <= sig_ok_d;
      end
   end

   assign fb           = fb_q;
   assign fb_rise      = fb_rise_q;
   assign period       = period_q;
   assign period_valid = period_valid_q;
   assign period_avg   = period_avg_q;
   assign too_fast     = too_fast_q;
   assign too_slow     = too_slow_q;
   assign sig_ok       = sig_ok_q;

endmodule

// File: tb/tb_fb_conditioner.sv
// tb/tb_fb_conditioner.sv - randomized self-checking bench for fb_conditioner
module tb_fb_conditioner;

   localparam int FL   = 3;
   localparam int PMIN = 238;
   localparam int PMAX = 1000;
   localparam int LOCK = 8;
   localparam int PB   = 16;

   logic          clk_50 = 1'b0;
   logic          rst_n  = 1'b1;
   logic          fb_u   = 1'b0;
   logic          fb, fb_rise, period_valid, too_fast, too_slow, sig_ok;
   logic [PB-1:0] period, period_avg;

   int errors = 0;
   int checks = 0;

   always #5 clk_50 = ~clk_50;

   fb_conditioner #(
      .FILTER_LEN(FL), .PERIOD_MIN(PMIN), .PERIOD_MAX(PMAX),
      .LOCK_COUNT(LOCK), .PERIOD_BITS(PB)
   ) dut (
      .clk_50(clk_50), .rst_n(rst_n), .fb_u(fb_u), .fb(fb), .fb_rise(fb_rise),
      .period(period), .period_valid(period_valid), .period_avg(period_avg),
      .too_fast(too_fast), .too_slow(too_slow), .sig_ok(sig_ok)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Event-level reference: rise times, period arithmetic, a queue of accepted periods.
   logic [31:0] raw_hist;
   int   t, t_ref, pend_p, good_m, m_period, m_avg;
   bit   pend, have_edge_m, m_fb, m_rise, m_pv, m_tf, m_ts, m_sig;
   int   acc_q[$];

   always @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         raw_hist = '0; t = 0; t_ref = 0; pend = 0; pend_p = 0; have_edge_m = 0;
         good_m = 0; m_period = 0; m_avg = 0; m_fb = 0; m_rise = 0;
         m_pv = 0; m_tf = 0; m_ts = 0; m_sig = 0;
         acc_q.delete();
      end else begin
         bit all_diff;
         t++;
         raw_hist = {raw_hist[30:0], fb_u};
         m_pv = 0; m_tf = 0; m_ts = 0; m_rise = 0;
         if (pend) begin
            pend = 0;
            if (!have_edge_m || pend_p > PMAX) begin
               have_edge_m = 1;
            end else if (pend_p < PMIN) begin
               m_tf = 1; good_m = 0; m_sig = 0;
            end else begin
               int s;
               m_pv = 1; m_period = pend_p;
               acc_q.push_back(pend_p);
               if (acc_q.size() > 4) void'(acc_q.pop_front());
               s = 0;
               foreach (acc_q[i]) s += acc_q[i];
               m_avg = s / 4;
               if (good_m < LOCK) good_m++;
               m_sig = (good_m == LOCK);
            end
         end
         if (t - t_ref == PMAX + 1) begin
            m_ts = 1; have_edge_m = 0; good_m = 0; m_sig = 0;
            acc_q.delete();
         end
         // Synced sample of edge t is the pin value two edges earlier.
         all_diff = 1;
         for (int k = 2; k <= FL + 1; k++) if (raw_hist[k] == m_fb) all_diff = 0;
         if (all_diff) begin
            m_fb = !m_fb;
            if (m_fb) begin
               m_rise = 1; pend = 1; pend_p = t - t_ref; t_ref = t;
            end
         end
      end
   end

   int ev[$];

   always @(negedge clk_50) begin
      chk("fb", int'(fb), int'(m_fb));
      chk("fb_rise", int'(fb_rise), int'(m_rise));
      chk("period", int'(period), m_period);
      chk("period_valid", int'(period_valid), int'(m_pv));
      chk("period_avg", int'(period_avg), m_avg);
      chk("too_fast", int'(too_fast), int'(m_tf));
      chk("too_slow", int'(too_slow), int'(m_ts));
      chk("sig_ok", int'(sig_ok), int'(m_sig));
      if (rst_n) begin
         if (period_valid) ev.push_back(int'(period));
         if (too_fast) ev.push_back(-1);
         if (too_slow) ev.push_back(-2);
      end
   end

   task automatic period_of(input int p);
      fb_u = 1'b1;
      repeat (p / 2) @(negedge clk_50);
      fb_u = 1'b0;
      repeat (p - p / 2) @(negedge clk_50);
   endtask

   task automatic rand_period();
      int p, hi, lo, g;
      p  = $urandom_range(200, 1100);
      hi = $urandom_range(8, p - 20);
      lo = p - hi;
      g  = $urandom_range(1, 2);
      fb_u = 1'b1;
      repeat (hi) @(negedge clk_50);
      fb_u = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
         repeat (lo / 2) @(negedge clk_50);
         fb_u = 1'b1;
         repeat (g) @(negedge clk_50);
         fb_u = 1'b0;
         repeat (lo - lo / 2 - g) @(negedge clk_50);
      end else begin
         repeat (lo) @(negedge clk_50);
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk_50);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_fb", int'(fb), 0);
      chk("rst_fb_rise", int'(fb_rise), 0);
      chk("rst_period", int'(period), 0);
      chk("rst_period_valid", int'(period_valid), 0);
      chk("rst_period_avg", int'(period_avg), 0);
      chk("rst_too_fast", int'(too_fast), 0);
      chk("rst_too_slow", int'(too_slow), 0);
      chk("rst_sig_ok", int'(sig_ok), 0);
      fb_u = 1'b0;
      @(negedge clk_50);
      @(negedge clk_50);
      rst_n = 1'b1;
   endtask

   task automatic check_log(input string name, input int exp[$]);
      chk({name, "_count"}, ev.size(), exp.size());
      for (int i = 0; i < ev.size() && i < exp.size(); i++) chk(name, ev[i], exp[i]);
   endtask

   task automatic count_to_too_slow(input string name, input int drop_at);
      int cnt;
      bit got;
      cnt = 0; got = 0;
      while (cnt < 1100 && !got) begin
         @(negedge clk_50);
         cnt++;
         if (cnt == drop_at) fb_u = 1'b0;
         if (too_slow) got = 1;
      end
      chk(name, cnt, 1001);
   endtask

   initial begin
      int lat, seen;
      bit found;
      int e1[$] = '{400, 400, 400, 400, 400, 400, 400, 400};
      int e3[$] = '{400, -1, -1, -1, 400, 400, 400, 400, 400, 400, 400, 400};
      int e5[$] = '{400, 238, 1000, -1, 400, -2, 400};
      int e4[$] = '{400, 400};

      #1 rst_n = 1'b0;
      reset_pulse();

      // Deglitch: 2-cycle pulse filtered, 3-cycle pulse passes with fixed latency.
      repeat (10) @(negedge clk_50);
      seen = 0;
      fb_u = 1'b1;
      @(negedge clk_50);
      @(negedge clk_50);
      fb_u = 1'b0;
      repeat (10) begin
         @(negedge clk_50);
         if (fb || fb_rise) seen = 1;
      end
      chk("glitch_blocked", seen, 0);
      lat = 0;
      fb_u = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk_50);
         if (k == 3) fb_u = 1'b0;
         if (fb && lat == 0) lat = k;
      end
      chk("filter_latency", lat, 5);

      // Clean 400-cycle square from a fresh start.
      reset_pulse();
      ev.delete();
      repeat (8) period_of(400);
      chk("sig_ok_7_accepted", int'(sig_ok), 0);
      period_of(400);
      chk("sig_ok_8_accepted", int'(sig_ok), 1);
      chk("lock_period", int'(period), 400);
      chk("lock_avg", int'(period_avg), 400);
      check_log("square_log", e1);

      // Too-fast episode and relock.
      ev.delete();
      repeat (3) period_of(200);
      chk("fast_sig_ok", int'(sig_ok), 0);
      chk("fast_period_held", int'(period), 400);
      repeat (8) period_of(400);
      chk("relock_7", int'(sig_ok), 0);
      period_of(400);
      chk("relock_8", int'(sig_ok), 1);
      check_log("fast_log", e3);

      // Boundaries and alternating average.
      ev.delete();
      period_of(238);
      period_of(1000);
      period_of(237);
      period_of(400);
      period_of(1001);
      period_of(400);
      period_of(400);
      check_log("bound_log", e5);
      repeat (5) begin
         period_of(400);
         period_of(404);
      end
      period_of(400);
      chk("alt_period", int'(period), 404);
      chk("alt_avg", int'(period_avg), 402);

      // Timeout after lock, then resume.
      found = 0;
      fb_u = 1'b1;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk_50);
         if (fb_rise) found = 1;
      end
      chk("timeout_rise_seen", int'(found), 1);
      count_to_too_slow("timeout_cycles", 200);
      chk("timeout_sig_ok", int'(sig_ok), 0);
      @(negedge clk_50);
      ev.delete();
      repeat (3) period_of(400);
      check_log("resume_log", e4);

      repeat (25) rand_period();

      // Asynchronous reset mid-stream, then idle.
      period_of(400);
      fb_u = 1'b1;
      repeat (37) @(negedge clk_50);
      @(negedge clk_50);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_fb", int'(fb), 0);
      chk("mid_rst_period", int'(period), 0);
      chk("mid_rst_avg", int'(period_avg), 0);
      chk("mid_rst_sig_ok", int'(sig_ok), 0);
      fb_u = 1'b0;
      @(negedge clk_50);
      rst_n = 1'b1;
      count_to_too_slow("post_reset_timeout", 0);
      repeat (4) period_of(300);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5ms;
      errors++;
      $display("FAIL watchdog: simulation did not complete, expected finish before 5 ms");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
